// File: rtl/uart_apb_scheduler_pkg.sv
// Shared constants for the UART APB scheduler: register offsets, status bit indices, state encodings.
package uart_sched_pkg;

  localparam logic [2:0] REG_TXDATA = 3'd0;
  localparam logic [2:0] REG_RXDATA = 3'd1;
  localparam logic [2:0] REG_CTRL1  = 3'd2;
  localparam logic [2:0] REG_CTRL2  = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam logic [2:0] REG_CTRL3  = 3'd5;

  localparam int ST_TXRDY    = 0;
  localparam int ST_RXRDY    = 1;
  localparam int ST_PARITY   = 2;
  localparam int ST_OVERFLOW = 3;
  localparam int ST_FRAMING  = 4;

  typedef enum logic [2:0] {
    CFG1, CFG2, CFG3, POLL, DECIDE, TXW, RXR, GAP
  } sched_state_t;

  typedef enum logic [1:0] {
    PH_IDLE, PH_SETUP, PH_ACCESS
  } xfer_phase_t;

  // UART registers sit on 32-bit word boundaries.
  function automatic logic [4:0] reg_addr(input logic [2:0] r);
    return {r, 2'b00};
  endfunction

endpackage

// File: rtl/uart_apb_scheduler_if.sv
// APB master bus between the scheduler and the UART register block.
interface uart_apb_scheduler_if;
  logic [4:0] M_PADDR;
  logic       M_PSEL;
  logic       M_PENABLE;
  logic       M_PWRITE;
  logic [7:0] M_PWDATA;
  logic [7:0] M_PRDATA;
  logic       M_PREADY;

  modport master (
    output M_PADDR, M_PSEL, M_PENABLE, M_PWRITE, M_PWDATA,
    input  M_PRDATA, M_PREADY
  );

  modport slave (
    input  M_PADDR, M_PSEL, M_PENABLE, M_PWRITE, M_PWDATA,
    output M_PRDATA, M_PREADY
  );
endinterface

// File: rtl/uart_apb_scheduler_apb_xfer.sv
// Two-phase APB transfer engine: start launches SETUP next cycle, done flags the ACCESS cycle with PREADY.
// A new start may be accepted in the done cycle so transfers run back to back; bus reads 0 when idle.
module uart_sched_apb_xfer
  import uart_sched_pkg::*;
(
  input  logic       pclk_i,
  input  logic       presetn_i,
  input  logic       start_i,
  input  logic [4:0] addr_i,
  input  logic       write_i,
  input  logic [7:0] wdata_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] rdata_o,
  uart_apb_scheduler_if.master apb
);

  xfer_phase_t phase_q, phase_d;
  logic [4:0]  addr_q;
  logic        write_q;
  logic [7:0]  wdata_q;

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      phase_q <= PH_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      phase_q <= phase_d;
      if (start_i) begin
        addr_q  <= addr_i;
        write_q <= write_i;
        wdata_q <= wdata_i;
      end
    end
  end

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_IDLE:   if (start_i) phase_d = PH_SETUP;
      PH_SETUP:  phase_d = PH_ACCESS;
      PH_ACCESS: if (apb.M_PREADY) phase_d = start_i ? PH_SETUP : PH_IDLE;
      default:   phase_d = PH_IDLE;
    endcase
  end

  assign busy_o        = (phase_q != PH_IDLE);
  assign done_o        = (phase_q == PH_ACCESS) && apb.M_PREADY;
  assign rdata_o       = apb.M_PRDATA;
  assign apb.M_PSEL    = busy_o;
  assign apb.M_PENABLE = (phase_q == PH_ACCESS);
  assign apb.M_PADDR   = busy_o ? addr_q  : 5'd0;
  assign apb.M_PWRITE  = busy_o ? write_q : 1'b0;
  assign apb.M_PWDATA  = busy_o ? wdata_q : 8'd0;

endmodule

// File: rtl/uart_apb_scheduler.sv
// Configures a UART over APB, then polls its status and round-robins between RX reads and TX writes.
module uart_apb_scheduler
  import uart_sched_pkg::*;
#(
  parameter logic [12:0] BAUD_VALUE = 13'd0,
  parameter logic [2:0]  BAUD_FRCTN = 3'd0,
  parameter logic        BIT8       = 1'b1,
  parameter logic        PARITY_EN  = 1'b0,
  parameter logic        ODD_N_EVEN = 1'b0,
  parameter int unsigned POLL_GAP   = 4
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  uart_apb_scheduler_if.master apb,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       cfg_done,
  output logic [2:0] err_flags,
  input  logic       err_clr
);

  localparam logic [7:0]   GAP_LAST      = (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);
  localparam sched_state_t AFTER_SERVICE = (POLL_GAP == 0) ? POLL : GAP;

  sched_state_t state_q, state_d;
  logic         last_tx_q, last_tx_d;
  logic [7:0]   gap_cnt_q, gap_cnt_d;
  logic [4:0]   status_q;
  logic         rx_valid_q, rx_valid_d;
  logic [7:0]   rx_data_q;
  logic         cfg_done_q;
  logic [2:0]   err_q, err_d, err_new;

  logic         xfer_start, xfer_write, xfer_busy, xfer_done;
  logic [4:0]   xfer_addr;
  logic [7:0]   xfer_wdata, xfer_rdata;
  logic         rx_elig, tx_elig, rx_load, poll_done;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q   <= CFG1;
      last_tx_q <= 1'b1;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      last_tx_q <= last_tx_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign rx_elig = status_q[ST_RXRDY] && !rx_valid_q;
  assign tx_elig = status_q[ST_TXRDY] && tx_valid;

  always_comb begin
    state_d   = state_q;
    last_tx_d = last_tx_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      CFG1:   if (xfer_done) state_d = CFG2;
      CFG2:   if (xfer_done) state_d = CFG3;
      CFG3:   if (xfer_done) state_d = POLL;
      POLL:   if (xfer_done) state_d = DECIDE;
      DECIDE: begin
        // On a tie the side not served last wins.
        if (rx_elig && (!tx_elig || last_tx_q)) begin
          state_d   = RXR;
          last_tx_d = 1'b0;
        end else if (tx_elig) begin
          state_d   = TXW;
          last_tx_d = 1'b1;
        end else begin
          state_d = AFTER_SERVICE;
        end
      end
      TXW, RXR: if (xfer_done) state_d = AFTER_SERVICE;
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = POLL;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: state_d = CFG1;
    endcase
  end

  // Launch parameters follow the next state so consecutive transfers need no idle cycle.
  always_comb begin
    xfer_addr  = '0;
    xfer_write = 1'b0;
    xfer_wdata = '0;
    xfer_start = 1'b0;
    case (state_d)
      CFG1: begin
        xfer_addr  = reg_addr(REG_CTRL1);
        xfer_write = 1'b1;
        xfer_wdata = BAUD_VALUE[7:0];
        xfer_start = 1'b1;
      end
      CFG2: begin
        xfer_addr  = reg_addr(REG_CTRL2);
        xfer_write = 1'b1;
        xfer_wdata = {BAUD_VALUE[12:8], ODD_N_EVEN, PARITY_EN, BIT8};
        xfer_start = 1'b1;
      end
      CFG3: begin
        xfer_addr  = reg_addr(REG_CTRL3);
        xfer_write = 1'b1;
        xfer_wdata = {5'b0, BAUD_FRCTN};
        xfer_start = 1'b1;
      end
      POLL: begin
        xfer_addr  = reg_addr(REG_STATUS);
        xfer_start = 1'b1;
      end
      TXW: begin
        xfer_addr  = reg_addr(REG_TXDATA);
        xfer_write = 1'b1;
        xfer_wdata = tx_data;
        xfer_start = 1'b1;
      end
      RXR: begin
        xfer_addr  = reg_addr(REG_RXDATA);
        xfer_start = 1'b1;
      end
      default: xfer_start = 1'b0;
    endcase
    if (xfer_busy && !xfer_done) xfer_start = 1'b0;
    tx_ready = (state_q == TXW) && xfer_done;
  end

  uart_sched_apb_xfer u_xfer (
    .pclk_i    (PCLK),
    .presetn_i (PRESETN),
    .start_i   (xfer_start),
    .addr_i    (xfer_addr),
    .write_i   (xfer_write),
    .wdata_i   (xfer_wdata),
    .busy_o    (xfer_busy),
    .done_o    (xfer_done),
    .rdata_o   (xfer_rdata),
    .apb       (apb)
  );

  assign poll_done  = (state_q == POLL) && xfer_done;
  assign rx_load    = (state_q == RXR) && xfer_done;
  assign rx_valid_d = rx_load || (rx_valid_q && !rx_ready);
  assign err_new    = poll_done ? {xfer_rdata[ST_FRAMING], xfer_rdata[ST_OVERFLOW],
                                   xfer_rdata[ST_PARITY]} : 3'b000;
  assign err_d      = (err_clr ? 3'b000 : err_q) | err_new;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      status_q   <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      cfg_done_q <= 1'b0;
      err_q      <= '0;
    end else begin
      if (poll_done) status_q <= xfer_rdata[4:0];
      if (rx_load) rx_data_q <= xfer_rdata;
      if ((state_q == CFG3) && xfer_done) cfg_done_q <= 1'b1;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
    end
  end

  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign cfg_done  = cfg_done_q;
  assign err_flags = err_q;

endmodule

// File: tb/tb_uart_apb_scheduler.sv
// Scoreboard bench for uart_apb_scheduler: expected APB transfers and RX bytes queued by stimulus, checked by a monitor.
module tb_uart_apb_scheduler;

  typedef struct packed {
    logic [4:0] addr;
    logic       wr;
    logic [7:0] data;
  } xact_t;

  logic PCLK = 1'b0;
  logic PRESETN = 1'b0;
  always #5 PCLK = ~PCLK;

  uart_apb_scheduler_if apb();

  logic       tx_valid, tx_ready, rx_valid, rx_ready, cfg_done, err_clr;
  logic [7:0] tx_data, rx_data;
  logic [2:0] err_flags;
  logic [7:0] st_val, rx_byte;
  logic       stall;

  uart_apb_scheduler #(
    .BAUD_VALUE (13'h1A5),
    .BAUD_FRCTN (3'd0),
    .BIT8       (1'b1),
    .PARITY_EN  (1'b1),
    .ODD_N_EVEN (1'b1),
    .POLL_GAP   (4)
  ) dut (
    .PCLK      (PCLK),
    .PRESETN   (PRESETN),
    .apb       (apb),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .cfg_done  (cfg_done),
    .err_flags (err_flags),
    .err_clr   (err_clr)
  );

  // UART register model: status and receive buffer reads, everything else reads 0.
  always_comb begin
    apb.M_PREADY = !stall;
    apb.M_PRDATA = 8'h00;
    if (apb.M_PADDR == 5'h10) apb.M_PRDATA = st_val;
    else if (apb.M_PADDR == 5'h04) apb.M_PRDATA = rx_byte;
  end

  int    checks = 0;
  int    errors = 0;
  int    txr_cnt = 0;
  xact_t exp_q[$];
  logic [7:0] rx_exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [4:0] su_addr;
  logic       su_wr;
  logic [7:0] su_data;

  always @(negedge PCLK) begin
    xact_t e;
    logic [7:0] rb;
    if (PRESETN) begin
      if (apb.M_PSEL && !apb.M_PENABLE) begin
        su_addr = apb.M_PADDR;
        su_wr   = apb.M_PWRITE;
        su_data = apb.M_PWDATA;
      end
      if (apb.M_PSEL && apb.M_PENABLE && apb.M_PREADY) begin
        check("stable_addr", apb.M_PADDR, su_addr);
        check("stable_write", apb.M_PWRITE, su_wr);
        check("stable_wdata", apb.M_PWDATA, su_data);
        if (!(apb.M_PADDR == 5'h10 && !apb.M_PWRITE)) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_xfer: addr 0x%0h write %0b data 0x%0h, expected none",
                     apb.M_PADDR, apb.M_PWRITE, apb.M_PWDATA);
          end else begin
            e = exp_q.pop_front();
            check("xfer_addr", apb.M_PADDR, e.addr);
            check("xfer_write", apb.M_PWRITE, e.wr);
            if (e.wr) check("xfer_wdata", apb.M_PWDATA, e.data);
          end
        end
      end
      if (tx_ready) begin
        txr_cnt++;
        check("tx_ready_in_txw_access",
              {apb.M_PSEL, apb.M_PENABLE, apb.M_PREADY, apb.M_PWRITE, apb.M_PADDR}, 9'b1111_00000);
      end
      if (rx_valid && rx_ready) begin
        if (rx_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rx: got 0x%0h, expected none", rx_data);
        end else begin
          rb = rx_exp_q.pop_front();
          check("rx_data", rx_data, rb);
        end
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_psel"}, apb.M_PSEL, 1'b0);
    check({tag, "_penable"}, apb.M_PENABLE, 1'b0);
    check({tag, "_pwrite"}, apb.M_PWRITE, 1'b0);
    check({tag, "_paddr"}, apb.M_PADDR, 5'h00);
    check({tag, "_pwdata"}, apb.M_PWDATA, 8'h00);
    check({tag, "_tx_ready"}, tx_ready, 1'b0);
    check({tag, "_rx_valid"}, rx_valid, 1'b0);
    check({tag, "_rx_data"}, rx_data, 8'h00);
    check({tag, "_cfg_done"}, cfg_done, 1'b0);
    check({tag, "_err_flags"}, err_flags, 3'b000);
  endtask

  task automatic release_and_check_cfg(input string tag);
    exp_q.push_back(xact_t'{5'h08, 1'b1, 8'hA5});
    exp_q.push_back(xact_t'{5'h0C, 1'b1, 8'h0F});
    exp_q.push_back(xact_t'{5'h14, 1'b1, 8'h00});
    @(negedge PCLK);
    PRESETN = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge PCLK);
      if (c == 1) begin
        check({tag, "_cyc1_setup"}, {apb.M_PSEL, apb.M_PENABLE}, 2'b10);
        check({tag, "_cyc1_addr"}, apb.M_PADDR, 5'h08);
      end
      if (c == 2) check({tag, "_cyc2_access"}, {apb.M_PSEL, apb.M_PENABLE}, 2'b11);
      if (c == 6) check({tag, "_cfg_done_cyc6"}, cfg_done, 1'b0);
      if (c == 7) check({tag, "_cfg_done_cyc7"}, cfg_done, 1'b1);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge PCLK);
      if (exp_q.size() == 0) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %0d transfers still pending, expected 0", name, exp_q.size());
    end
  endtask

  task automatic wait_txr(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge PCLK);
      if (tx_ready) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: tx_ready 0 for 200 cycles, expected a pulse", name);
    end
  endtask

  task automatic wait_poll(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge PCLK);
      if (apb.M_PSEL && apb.M_PENABLE && apb.M_PREADY && apb.M_PADDR == 5'h10) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: no status poll in 200 cycles, expected one", name);
    end
  endtask

  task automatic wait_rx_valid(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge PCLK);
      if (rx_valid) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: rx_valid 0 for 200 cycles, expected 1", name);
    end
  endtask

  initial begin
    tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0; err_clr = 1'b0;
    st_val = 8'h00; rx_byte = 8'h00; stall = 1'b0;
    repeat (3) @(negedge PCLK);
    check_outputs_zero("reset");

    // Configuration sequence and cfg_done timing
    release_and_check_cfg("cfg");
    wait_drain("cfg_drain", 20);

    // Single TX
    tx_data = 8'h55; tx_valid = 1'b1; st_val = 8'h01;
    exp_q.push_back(xact_t'{5'h00, 1'b1, 8'h55});
    wait_txr("tx_single");
    @(posedge PCLK); #1;
    tx_valid = 1'b0; st_val = 8'h00;
    repeat (30) @(negedge PCLK);
    check("tx_ready_count_1", txr_cnt, 1);
    check("tx_single_drained", exp_q.size(), 0);

    // RX and TX both eligible: RX first, TX on the following poll
    rx_ready = 1'b1; rx_byte = 8'h3C; tx_data = 8'hA6; tx_valid = 1'b1;
    exp_q.push_back(xact_t'{5'h04, 1'b0, 8'h00});
    exp_q.push_back(xact_t'{5'h00, 1'b1, 8'hA6});
    rx_exp_q.push_back(8'h3C);
    st_val = 8'h03;
    wait_txr("rr_tx");
    @(posedge PCLK); #1;
    tx_valid = 1'b0; st_val = 8'h00;
    repeat (30) @(negedge PCLK);
    check("tx_ready_count_2", txr_cnt, 2);
    check("rr_drained", exp_q.size(), 0);
    check("rr_rx_consumed", rx_exp_q.size(), 0);

    // Held rx_valid blocks further RX reads
    rx_ready = 1'b0; rx_byte = 8'h81;
    exp_q.push_back(xact_t'{5'h04, 1'b0, 8'h00});
    rx_exp_q.push_back(8'h81);
    st_val = 8'h02;
    wait_rx_valid("rx_hold_load");
    repeat (40) @(negedge PCLK);
    check("rx_hold_valid", rx_valid, 1'b1);
    check("rx_hold_data", rx_data, 8'h81);
    rx_byte = 8'h42;
    exp_q.push_back(xact_t'{5'h04, 1'b0, 8'h00});
    rx_exp_q.push_back(8'h42);
    rx_ready = 1'b1;
    wait_drain("rx_resume", 100);
    st_val = 8'h00;
    repeat (20) @(negedge PCLK);
    check("rx_resume_consumed", rx_exp_q.size(), 0);
    check("rx_resume_valid", rx_valid, 1'b0);

    // Sticky error flags and clear priority
    check("err_initial", err_flags, 3'b000);
    st_val = 8'h04;
    wait_poll("err_parity_poll");
    @(negedge PCLK);
    check("err_parity", err_flags, 3'b001);
    st_val = 8'h1C;
    wait_poll("err_all_poll");
    err_clr = 1'b1;
    @(negedge PCLK);
    err_clr = 1'b0;
    check("err_clr_vs_new_all", err_flags, 3'b111);
    st_val = 8'h08;
    wait_poll("err_ovf_poll");
    err_clr = 1'b1;
    @(negedge PCLK);
    err_clr = 1'b0;
    check("err_clr_vs_new_ovf", err_flags, 3'b010);
    st_val = 8'h00;
    @(negedge PCLK);
    err_clr = 1'b1;
    @(negedge PCLK);
    err_clr = 1'b0;
    check("err_cleared", err_flags, 3'b000);

    // Reset during a stalled TX write
    tx_data = 8'h77; tx_valid = 1'b1; st_val = 8'h01;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge PCLK);
        if (apb.M_PSEL && !apb.M_PENABLE && apb.M_PWRITE && apb.M_PADDR == 5'h00) seen = 1'b1;
      end
      check("txw_setup_seen", seen, 1'b1);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      check("stall_access", {apb.M_PSEL, apb.M_PENABLE, tx_ready}, 3'b110);
    end
    PRESETN = 1'b0;
    #1;
    check_outputs_zero("midxfer_reset");
    tx_valid = 1'b0; st_val = 8'h00; stall = 1'b0;
    repeat (2) @(negedge PCLK);
    check("tx_ready_count_after_reset", txr_cnt, 2);
    release_and_check_cfg("recfg");
    wait_drain("recfg_drain", 20);
    repeat (20) @(negedge PCLK);
    check("final_no_pending", exp_q.size(), 0);
    check("final_rx_pending", rx_exp_q.size(), 0);
    check("final_tx_ready_count", txr_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_apb_scheduler.md
UART_APB_SCHEDULER -- requirements
Module: uart_apb_scheduler

Interface
REQ-001 SHALL have parameter BAUD_VALUE, default 0: 13-bit baud divisor written to the UART.
REQ-002 SHALL have parameter BAUD_FRCTN, default 0: 3-bit fractional baud code.
REQ-003 SHALL have parameter BIT8, default 1: 8-bit data when 1.
REQ-004 SHALL have parameter PARITY_EN, default 0: parity enabled when 1.
REQ-005 SHALL have parameter ODD_N_EVEN, default 0: odd parity when 1.
REQ-006 SHALL have parameter POLL_GAP, default 4: idle cycles between status polls, range 0..255.
REQ-007 SHALL have one clock and an asynchronous, active-low reset.
REQ-008 PCLK  in  1  sole clock; all logic on the rising edge.
REQ-009 PRESETN  in  1  asynchronous active-low reset.
REQ-010 M_PADDR  out  5  APB master address.
REQ-011 M_PSEL, M_PENABLE, M_PWRITE  out  1 each  APB master controls.
REQ-012 M_PWDATA  out  8  APB write data.
REQ-013 M_PRDATA  in  8  APB read data.
REQ-014 M_PREADY  in  1  APB transfer complete.
REQ-015 tx_valid  in  1, and tx_data  in  8  client byte to transmit.
REQ-016 tx_ready  out  1  one-cycle accept pulse.
REQ-017 rx_valid  out  1, and rx_data  out  8  received byte holding register.
REQ-018 rx_ready  in  1  client consumes rx_data.
REQ-019 cfg_done  out  1  configuration complete.
REQ-020 err_flags  out  3  sticky errors {framing, overflow, parity}.
REQ-021 err_clr  in  1  clears err_flags.

Function
REQ-022 Each APB transfer SHALL have a SETUP cycle (PSEL=1, PENABLE=0), then ACCESS cycles (PSEL=1, PENABLE=1) held until PREADY=1; address, data and PWRITE stay stable across both phases.
REQ-023 The FSM SHALL have states CFG1, CFG2, CFG3, POLL, DECIDE, TXW, RXR and GAP.
REQ-024 After reset, CFG1 SHALL write 0x08 with BAUD_VALUE[7:0].
REQ-025 CFG2 SHALL then write 0x0C with {BAUD_VALUE[12:8], ODD_N_EVEN, PARITY_EN, BIT8}.
REQ-026 CFG3 SHALL then write 0x14 with {5'b0, BAUD_FRCTN}.
REQ-027 cfg_done SHALL rise the cycle after the CFG3 ACCESS completes, and stay high until reset.
REQ-028 POLL SHALL read 0x10; status bits: [0] TXRDY, [1] RXRDY, [2] parity, [3] overflow, [4] framing.
REQ-029 M_PRDATA SHALL be sampled only in the ACCESS cycle where PREADY=1.
REQ-030 On each poll, status bits [4], [3] and [2] SHALL be OR-ed into err_flags[2], [1] and [0].
REQ-031 DECIDE (1 cycle): RX is eligible when RXRDY=1 and rx_valid=0; TX is eligible when TXRDY=1 and tx_valid=1.
REQ-032 When both are eligible, the requester not served last SHALL win (round-robin, last_served resets to TX so RX wins first).
REQ-033 When neither is eligible, the FSM SHALL go to GAP.
REQ-034 RXR SHALL read 0x04; at ACCESS completion, rx_data is loaded and rx_valid=1.
REQ-035 TXW SHALL write 0x00 with tx_data; tx_ready is pulsed in the ACCESS cycle where PREADY=1.
REQ-036 tx_data SHALL be sampled in the SETUP cycle.
REQ-037 After TXW or RXR, the FSM SHALL go to GAP.
REQ-038 GAP SHALL count POLL_GAP cycles, then go to POLL; with POLL_GAP=0, POLL follows TXW, RXR or DECIDE directly.
REQ-039 rx_valid SHALL clear on rx_valid & rx_ready; a simultaneous load and consume SHALL leave rx_valid=1 with the new data.
REQ-040 err_clr SHALL zero err_flags; a same-cycle new error bit SHALL win and be set.
REQ-041 Bus outputs SHALL be 0 in POLL-free idle (GAP, DECIDE); M_PADDR SHALL use the word address {reg[2:0], 2'b00}.

Reset
REQ-042 On PRESETN low, all outputs SHALL go to 0 immediately (asynchronously), the FSM to CFG1, last_served to TX, and the GAP counter to 0.
REQ-043 A reset mid-transfer SHALL abort the transfer; no tx_ready and no rx_valid result.

Structure
REQ-044 Package uart_sched_pkg SHALL hold the register offset constants (TXDATA 0, RXDATA 1, CTRL1 2, CTRL2 3, STATUS 4, CTRL3 5), the status bit indices and the FSM state enum.
REQ-045 One sub-module, uart_sched_apb_xfer, SHALL be the two-phase APB transfer engine (start/done handshake); the arbiter and FSM stay in the top.

Verification
REQ-046 Reset release, BAUD_VALUE=0x1A5, BIT8=1, PARITY_EN=1, ODD_N_EVEN=1, PREADY=1 -> writes 0x08=0xA5, 0x0C=0x0F, 0x14=0x00, and cfg_done high in cycle 7.
REQ-047 Status 0x01 and tx_valid=1 with tx_data=0x55 -> write 0x00=0x55, and a single tx_ready pulse.
REQ-048 Status 0x03, rx_valid=0, tx_valid=1 on two consecutive polls -> RX read first, TX write second.
REQ-049 Status 0x02 with rx_valid=1 held (rx_ready=0) -> no 0x04 read until the client consumes.
REQ-050 Status 0x1C with err_clr asserted in the same cycle -> err_flags=3'b111.
REQ-051 PREADY held low for 3 cycles during TXW, then reset -> bus idles at 0, the FSM restarts at CFG1, and no tx_ready occurs.
